// File: rtl/rgb_led_pwm_driver.sv
// RGB status driver for NUM_LEDS LEDs: maps game state/timer to solid, blink or sweep
// patterns, dimmed by a free-running PWM. All outputs are registered.
module rgb_led_pwm_driver #(
    parameter int NUM_LEDS    = 4,
    parameter int PWM_BITS    = 8,
    parameter int TIMER_W     = 7,
    parameter int BLINK_HALF  = 25000000,
    parameter int WARN_THRESH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          state,
    input  logic                timer_running,
    input  logic [TIMER_W-1:0]  timer,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_LEDS-1:0] led_red,
    output logic [NUM_LEDS-1:0] led_green,
    output logic [NUM_LEDS-1:0] led_blue
);

    localparam int CNT_W = $clog2(BLINK_HALF);
    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    typedef enum logic [1:0] {
        MODE_OFF,
        MODE_SOLID,
        MODE_BLINK,
        MODE_SWEEP
    } mode_e;

    // Colour is a {red, green, blue} channel set.
    localparam logic [2:0] COL_NONE   = 3'b000;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_YELLOW = 3'b110;

    mode_e               sel_mode, mode_q;
    logic [2:0]          sel_colour, colour_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [CNT_W-1:0]    blink_cnt;
    logic                blink_on;
    logic [IDX_W-1:0]    sweep_idx;
    logic                pwm_on;
    logic                restart;
    logic                blink_wrap;
    logic [NUM_LEDS-1:0] led_mask;

    // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        sel_mode   = MODE_OFF;
        sel_colour = COL_NONE;
        case (state)
            3'b001: begin
                if (timer_running) begin
                    if (timer > TIMER_W'(WARN_THRESH)) begin
                        sel_mode   = MODE_SOLID;
                        sel_colour = COL_YELLOW;
                    end else if (timer != '0) begin
                        sel_mode   = MODE_BLINK;
                        sel_colour = COL_YELLOW;
                    end else begin
                        sel_mode   = MODE_SOLID;
                        sel_colour = COL_GREEN;
                    end
                end
            end
            3'b011: begin
                sel_mode   = MODE_BLINK;
                sel_colour = COL_RED;
            end
            3'b101: begin
                sel_mode   = MODE_SWEEP;
                sel_colour = COL_GREEN;
            end
            default: ;
        endcase
    end

    assign restart    = (sel_mode != mode_q) || (sel_colour != colour_q);
    assign blink_wrap = (blink_cnt == CNT_W'(BLINK_HALF - 1));
    assign pwm_on     = (brightness == {PWM_BITS{1'b1}}) || (pwm_cnt < brightness);

    always_comb begin
        led_mask = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_q)
                MODE_SOLID: led_mask[i] = 1'b1;
                MODE_BLINK: led_mask[i] = blink_on;
                MODE_SWEEP: led_mask[i] = (sweep_idx == IDX_W'(i));
                default:    led_mask[i] = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_OFF;
            colour_q  <= COL_NONE;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            sweep_idx <= '0;
            led_red   <= '0;
            led_green <= '0;
            led_blue  <= '0;
        end else begin
            mode_q   <= sel_mode;
            colour_q <= sel_colour;
            pwm_cnt  <= pwm_cnt + 1'b1;

            // A new pattern always begins lit at LED 0, overriding a coincident wrap.
            if (restart) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
                sweep_idx <= '0;
            end else if (blink_wrap) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
                sweep_idx <= (sweep_idx == IDX_W'(NUM_LEDS - 1)) ? '0 : sweep_idx + 1'b1;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            led_red   <= led_mask & {NUM_LEDS{pwm_on & colour_q[2]}};
            led_green <= led_mask & {NUM_LEDS{pwm_on & colour_q[1]}};
            led_blue  <= led_mask & {NUM_LEDS{pwm_on & colour_q[0]}};
        end
    end

endmodule

// File: tb/tb_rgb_led_pwm_driver.sv
// Scoreboard bench for rgb_led_pwm_driver: the stimulus side predicts each output word from
// pattern age and cycle number; a monitor pops and compares one word per clock.
module tb_rgb_led_pwm_driver;

    localparam int N  = 4;
    localparam int PB = 4;
    localparam int TW = 7;
    localparam int BH = 8;
    localparam int WT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    state = 3'b011;
    logic          timer_running = 1'b0;
    logic [TW-1:0] timer = '0;
    logic [PB-1:0] brightness = '1;
    logic [N-1:0]  led_red, led_green, led_blue;

    rgb_led_pwm_driver #(
        .NUM_LEDS(N), .PWM_BITS(PB), .TIMER_W(TW), .BLINK_HALF(BH), .WARN_THRESH(WT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .timer_running(timer_running),
        .timer(timer), .brightness(brightness),
        .led_red(led_red), .led_green(led_green), .led_blue(led_blue)
    );

    always #5 clk = ~clk;

    // Pattern: mode 0 off, 1 solid, 2 blink, 3 sweep; r/g colour channels.
    typedef struct packed {
        logic [1:0] mode;
        logic       r;
        logic       g;
    } pat_t;

    typedef struct packed {
        logic [N-1:0] r;
        logic [N-1:0] g;
        logic [N-1:0] b;
    } leds_t;

    leds_t exp_q[$];
    int    step_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    k = 0;        // posedges since reset release
    int    s = 0;        // edge on which the current pattern was first registered
    int    step_no = 0;
    pat_t  prev = '0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %03h expected %03h", name, act, expv);
        end
    endtask

    function automatic pat_t select_pat(input logic [2:0] st, input logic run, input int t);
        pat_t p;
        p = '0;
        if (st == 3'b001 && run) begin
            if (t > WT)     p = {2'd1, 1'b1, 1'b1};
            else if (t > 0) p = {2'd2, 1'b1, 1'b1};
            else            p = {2'd1, 1'b0, 1'b1};
        end else if (st == 3'b011) begin
            p = {2'd2, 1'b1, 1'b0};
        end else if (st == 3'b101) begin
            p = {2'd3, 1'b0, 1'b1};
        end
        return p;
    endfunction

    // age = clocks the pattern has been held before this edge; PWM phase = cycles since reset mod 16.
    function automatic leds_t expect_leds(input pat_t p, input int age, input int edge_no, input int br);
        leds_t e;
        int    phase;
        bit    pwm;
        bit    m;
        e     = '0;
        phase = age / BH;
        pwm   = (br == 15) || (((edge_no - 1) % 16) < br);
        for (int i = 0; i < N; i++) begin
            case (p.mode)
                2'd1:    m = 1'b1;
                2'd2:    m = (phase % 2 == 0);
                2'd3:    m = (i == phase % N);
                default: m = 1'b0;
            endcase
            e.r[i] = m & pwm & p.r;
            e.g[i] = m & pwm & p.g;
        end
        return e;
    endfunction

    // Called just after a negedge; applies inputs for the coming posedge and predicts its result.
    task automatic step(input logic [2:0] st, input logic run, input int t, input int br);
        pat_t cur;
        state         = st;
        timer_running = run;
        timer         = TW'(t);
        brightness    = PB'(br);
        k++;
        cur = select_pat(st, run, t);
        exp_q.push_back(expect_leds(prev, k - 1 - s, k, br));
        step_q.push_back(step_no);
        step_no++;
        if (cur != prev) s = k;
        prev = cur;
        @(negedge clk);
    endtask

    task automatic run_steps(input int n, input logic [2:0] st, input logic run, input int t, input int br);
        for (int i = 0; i < n; i++) step(st, run, t, br);
    endtask

    task automatic model_reset();
        k    = 0;
        s    = 0;
        prev = '0;
    endtask

    // Assert reset mid-cycle, check outputs clear at once, release on a negedge.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", int'({led_red, led_green, led_blue}), 0);
        repeat (2) @(negedge clk);
        check("reset_held", int'({led_red, led_green, led_blue}), 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    always @(posedge clk) begin
        leds_t e;
        int    sn;
        #2;
        if (rst_n && exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            sn = step_q.pop_front();
            check($sformatf("leds_step%0d", sn), int'({led_red, led_green, led_blue}), int'(e));
        end
    end

    initial begin
        logic [2:0] st_tab [7];
        logic [2:0] st;
        logic       run;
        int         t, br, len;
        st_tab = '{3'b001, 3'b001, 3'b011, 3'b101, 3'b000, 3'b111, 3'b010};

        repeat (2) @(negedge clk);
        check("power_on_reset", int'({led_red, led_green, led_blue}), 0);
        rst_n = 1'b1;
        model_reset();

        run_steps(24, 3'b011, 1'b0, 0, 15);
        reset_mid();
        run_steps(20, 3'b011, 1'b0, 0, 15);

        run_steps(20, 3'b001, 1'b1, 10, 15);
        run_steps(20, 3'b001, 1'b1, 2, 15);
        run_steps(10, 3'b001, 1'b1, 0, 15);
        run_steps(6,  3'b001, 1'b0, 0, 15);

        run_steps(40, 3'b101, 1'b0, 0, 15);

        run_steps(34, 3'b011, 1'b0, 0, 4);
        run_steps(16, 3'b011, 1'b0, 0, 0);
        run_steps(16, 3'b011, 1'b0, 0, 15);

        // Enter GAME OVER, then switch to GAME CLEAR exactly on the blink wrap edge.
        run_steps(4,  3'b000, 1'b0, 0, 15);
        run_steps(8,  3'b011, 1'b0, 0, 15);
        run_steps(20, 3'b101, 1'b0, 0, 15);
        run_steps(12, 3'b011, 1'b0, 0, 15);

        run_steps(10, 3'b000, 1'b1, 5, 15);
        run_steps(10, 3'b111, 1'b1, 5, 15);

        for (int seg = 0; seg < 40; seg++) begin
            st  = st_tab[$urandom_range(0, 6)];
            run = ($urandom % 4) != 0;
            t   = $urandom_range(0, 12);
            case ($urandom % 4)
                0:       br = 0;
                1:       br = 15;
                default: br = $urandom_range(0, 15);
            endcase
            len = $urandom_range(3, 20);
            for (int i = 0; i < len; i++) begin
                if (run && t > 0 && ($urandom % 3) == 0) t--;
                if (($urandom % 8) == 0) br = $urandom_range(0, 15);
                step(st, run, t, br);
            end
            if (seg == 20) reset_mid();
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
